// File: rtl/div_seq_ctrl_pkg.sv
// Shared constants, state encodings and helpers for the multi-cycle DIV/DIVU unit.
// Used by the handshake interface, the iteration step and the sequencer.
package div_seq_ctrl_pkg;

  localparam int DATA_W    = 32;
  localparam int STEPS     = DATA_W;
  localparam int DIV_STEPS = STEPS;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_t;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is correct as unsigned.
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? -v : v;
  endfunction

endpackage

// File: rtl/div_seq_ctrl_if.sv
// Request/result handshake between the EX stage (master) and the divider (slave).
interface div_seq_ctrl_if import div_seq_ctrl_pkg::*; ();

  logic                start_i;
  logic                annul_i;
  logic                signed_div_i;
  logic [DATA_W-1:0]   opdata1_i;
  logic [DATA_W-1:0]   opdata2_i;
  logic [2*DATA_W-1:0] result_o;
  logic                ready_o;
  logic                busy_o;

  modport master (
    output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    output result_o, ready_o, busy_o
  );

endinterface

// File: rtl/div_seq_ctrl_step.sv
// One restoring-division iteration on the packed {remainder, quotient} register.
module div_seq_ctrl_step import div_seq_ctrl_pkg::*; (
  input  logic [2*DATA_W-1:0] work,
  input  logic [DATA_W-1:0]   divisor,
  output logic [2*DATA_W-1:0] work_next
);

  logic [DATA_W:0]   rem_shift;
  logic [DATA_W-1:0] diff;
  logic              fits;

  // The shifted partial remainder can need one extra bit before the trial subtract.
  assign rem_shift = work[2*DATA_W-1:DATA_W-1];
  assign fits      = rem_shift >= {1'b0, divisor};
  assign diff      = rem_shift[DATA_W-1:0] - divisor;

  assign work_next = fits ? {diff, work[DATA_W-2:0], 1'b1}
                          : {rem_shift[DATA_W-1:0], work[DATA_W-2:0], 1'b0};

endmodule

// File: rtl/div_seq_ctrl.sv
// DIV/DIVU sequencer: accepts an operand pair, runs 32 restoring steps and returns
// {remainder, quotient}; stalls the pipeline while busy and honours EX flushes.
module div_seq_ctrl import div_seq_ctrl_pkg::*; (
  input  logic          clk,
  input  logic          rst,
  div_seq_ctrl_if.slave bus
);

  div_state_t           state_reg;
  logic [DIV_CNT_W-1:0] cnt_reg;
  logic [2*DATA_W-1:0]  work_reg;
  logic [2*DATA_W-1:0]  work_next;
  logic [DATA_W-1:0]    divisor_reg;
  logic                 signed_reg;
  logic                 sign1_reg;
  logic                 sign2_reg;
  logic [2*DATA_W-1:0]  result_reg;
  logic                 ready_reg;
  logic [DATA_W-1:0]    quo_fix;
  logic [DATA_W-1:0]    rem_fix;
  logic                 busy;
  logic                 accept;

  div_seq_ctrl_step u_step (
    .work      (work_reg),
    .divisor   (divisor_reg),
    .work_next (work_next)
  );

  assign accept = (bus.start_i == DivStart) && !bus.annul_i;

  // Quotient sign follows the operand-sign XOR, remainder follows the dividend.
  assign quo_fix = (signed_reg && (sign1_reg ^ sign2_reg)) ? -work_next[DATA_W-1:0]
                                                           : work_next[DATA_W-1:0];
  assign rem_fix = (signed_reg && sign1_reg) ? -work_next[2*DATA_W-1:DATA_W]
                                             : work_next[2*DATA_W-1:DATA_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= DIV_IDLE;
      cnt_reg     <= '0;
      work_reg    <= '0;
      divisor_reg <= '0;
      signed_reg  <= 1'b0;
      sign1_reg   <= 1'b0;
      sign2_reg   <= 1'b0;
      result_reg  <= '0;
      ready_reg   <= DivResultNotReady;
    end else begin
      case (state_reg)
        DIV_IDLE: begin
          result_reg <= '0;
          ready_reg  <= DivResultNotReady;
          if (accept) begin
            if (bus.opdata2_i == '0) begin
              state_reg <= DIV_BYZERO;
            end else begin
              state_reg   <= DIV_ON;
              cnt_reg     <= '0;
              signed_reg  <= bus.signed_div_i;
              sign1_reg   <= bus.opdata1_i[DATA_W-1];
              sign2_reg   <= bus.opdata2_i[DATA_W-1];
              work_reg    <= {{DATA_W{1'b0}},
                              bus.signed_div_i ? abs_val(bus.opdata1_i) : bus.opdata1_i};
              divisor_reg <= bus.signed_div_i ? abs_val(bus.opdata2_i) : bus.opdata2_i;
            end
          end
        end
        DIV_BYZERO: begin
          state_reg  <= DIV_END;
          result_reg <= '0;
          ready_reg  <= DivResultReady;
        end
        DIV_ON: begin
          if (bus.annul_i) begin
            state_reg  <= DIV_IDLE;
            result_reg <= '0;
            ready_reg  <= DivResultNotReady;
          end else begin
            work_reg <= work_next;
            cnt_reg  <= cnt_reg + DIV_CNT_W'(1);
            if (cnt_reg == DIV_CNT_W'(DIV_STEPS - 1)) begin
              state_reg  <= DIV_END;
              result_reg <= {rem_fix, quo_fix};
              ready_reg  <= DivResultReady;
            end
          end
        end
        DIV_END: begin
          // Result is held for as long as EX keeps the request asserted.
          if (bus.start_i == DivStop) begin
            state_reg  <= DIV_IDLE;
            result_reg <= '0;
            ready_reg  <= DivResultNotReady;
          end
        end
        default: state_reg <= DIV_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    if (!bus.annul_i) begin
      case (state_reg)
        DIV_IDLE:           busy = (bus.start_i == DivStart);
        DIV_BYZERO, DIV_ON: busy = 1'b1;
        default:            busy = 1'b0;
      endcase
    end
  end

  assign bus.busy_o   = busy;
  assign bus.result_o = result_reg;
  assign bus.ready_o  = ready_reg;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: directed scenarios plus random operands
// compared against a plain-arithmetic division model.
module tb_div_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  div_seq_ctrl_if bus ();

  div_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    int signed   sa;
    int signed   sb;
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return 64'd0;
    if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      sa = a;
      sb = b;
      q  = sa / sb;
      r  = sa % sb;
    end
    return {r, q};
  endfunction

  // Drives a request and waits (bounded) for ready; operands are scrambled after acceptance.
  task automatic do_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                       output logic [63:0] res, output int edges, output int busy_bad);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    busy_bad         = 0;
    edges            = 0;
    #1;
    if (bus.busy_o !== 1'b1) busy_bad++;
    do begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 1) begin
        bus.opdata1_i    = $urandom;
        bus.opdata2_i    = $urandom;
        bus.signed_div_i = $urandom_range(0, 1);
      end
      if (bus.ready_o !== 1'b1 && bus.busy_o !== 1'b1) busy_bad++;
    end while (bus.ready_o !== 1'b1 && edges < 100);
    res = bus.result_o;
    $display("op sgn=%0d a=%h b=%h edges=%0d result=%h", sgn, a, b, edges, res);
  endtask

  task automatic release_op();
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.start_i = 0; bus.annul_i = 0; bus.signed_div_i = 0;
    bus.opdata1_i = 0; bus.opdata2_i = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.result_o !== 64'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", bus.result_o); end
    checks++; if (bus.ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", bus.ready_o); end
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_unsigned_basic();
    logic [63:0] res;
    int edges, bb;
    do_op(1'b0, 32'd100, 32'd7, res, edges, bb);
    checks++; if (edges !== 33) begin failures++; $display("FAIL u100_7_latency got=%0d exp=33", edges); end
    checks++; if (res !== 64'h0000_0002_0000_000E) begin failures++; $display("FAIL u100_7_result got=%h exp=00000002_0000000e", res); end
    checks++; if (bb !== 0) begin failures++; $display("FAIL u100_7_busy_wait low_cycles=%0d exp=0", bb); end
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL u100_7_busy_end got=%b exp=0", bus.busy_o); end
    release_op();
    checks++; if (bus.ready_o !== 1'b0) begin failures++; $display("FAIL u100_7_release_ready got=%b exp=0", bus.ready_o); end
  endtask

  task automatic test_signed();
    logic [63:0] res;
    int edges, bb;
    logic [31:0] av [3];
    logic [31:0] bv [3];
    av = '{32'hFFFF_FFF9, 32'h0000_0007, 32'h8000_0000};
    bv = '{32'h0000_0002, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    for (int i = 0; i < 3; i++) begin
      do_op(1'b1, av[i], bv[i], res, edges, bb);
      checks++; if (res !== ref_div(1'b1, av[i], bv[i])) begin failures++; $display("FAIL signed_result idx=%0d got=%h exp=%h", i, res, ref_div(1'b1, av[i], bv[i])); end
      checks++; if (edges !== 33) begin failures++; $display("FAIL signed_latency idx=%0d got=%0d exp=33", i, edges); end
      release_op();
    end
  endtask

  task automatic test_div_zero();
    logic [63:0] res;
    int edges, bb;
    do_op(1'b0, 32'h1234, 32'd0, res, edges, bb);
    checks++; if (edges !== 2) begin failures++; $display("FAIL divzero_latency got=%0d exp=2", edges); end
    checks++; if (res !== 64'd0) begin failures++; $display("FAIL divzero_result got=%h exp=0", res); end
    checks++; if (bb !== 0) begin failures++; $display("FAIL divzero_busy_wait low_cycles=%0d exp=0", bb); end
    release_op();
    checks++; if (bus.ready_o !== 1'b0) begin failures++; $display("FAIL divzero_release_ready got=%b exp=0", bus.ready_o); end
  endtask

  task automatic test_annul();
    logic [63:0] res;
    int edges, bb, ready_seen;
    ready_seen = 0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'hFFFF_FFFF;
    bus.opdata2_i    = 32'd3;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus.ready_o !== 1'b0) ready_seen++;
    end
    bus.annul_i = 1'b1;
    #1;
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL annul_busy_comb got=%b exp=0", bus.busy_o); end
    @(posedge clk);
    #1;
    if (bus.ready_o !== 1'b0) ready_seen++;
    checks++; if (ready_seen !== 0) begin failures++; $display("FAIL annul_ready_seen got=%0d exp=0", ready_seen); end
    checks++; if (bus.result_o !== 64'd0) begin failures++; $display("FAIL annul_result got=%h exp=0", bus.result_o); end
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL annul_busy_idle got=%b exp=0", bus.busy_o); end
    do_op(1'b0, 32'd9, 32'd3, res, edges, bb);
    checks++; if (res !== 64'h0000_0000_0000_0003) begin failures++; $display("FAIL annul_restart_result got=%h exp=3", res); end
    checks++; if (edges !== 33) begin failures++; $display("FAIL annul_restart_latency got=%0d exp=33", edges); end
    release_op();
  endtask

  task automatic test_hold_end();
    logic [63:0] res;
    logic [63:0] exp;
    int edges, bb;
    exp = ref_div(1'b0, 32'd1000, 32'd13);
    do_op(1'b0, 32'd1000, 32'd13, res, edges, bb);
    checks++; if (res !== exp) begin failures++; $display("FAIL hold_result got=%h exp=%h", res, exp); end
    bus.annul_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++; if (bus.ready_o !== 1'b1) begin failures++; $display("FAIL hold_ready cyc=%0d got=%b exp=1", i, bus.ready_o); end
      checks++; if (bus.result_o !== exp) begin failures++; $display("FAIL hold_stable cyc=%0d got=%h exp=%h", i, bus.result_o, exp); end
    end
    bus.annul_i = 1'b0;
    release_op();
    checks++; if (bus.ready_o !== 1'b0) begin failures++; $display("FAIL hold_release_ready got=%b exp=0", bus.ready_o); end
    checks++; if (bus.result_o !== 64'd0) begin failures++; $display("FAIL hold_release_result got=%h exp=0", bus.result_o); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] res;
    int edges, bb;
    bus.signed_div_i = 1'b1;
    bus.opdata1_i    = 32'hDEAD_BEEF;
    bus.opdata2_i    = 32'd17;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    repeat (21) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus.ready_o !== 1'b0) begin failures++; $display("FAIL rstmid_ready got=%b exp=0", bus.ready_o); end
    checks++; if (bus.result_o !== 64'd0) begin failures++; $display("FAIL rstmid_result got=%h exp=0", bus.result_o); end
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy_o); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_op(1'b0, 32'd77, 32'd5, res, edges, bb);
    checks++; if (res !== ref_div(1'b0, 32'd77, 32'd5)) begin failures++; $display("FAIL rstmid_after_result got=%h exp=%h", res, ref_div(1'b0, 32'd77, 32'd5)); end
    release_op();
  endtask

  task automatic test_random();
    logic [63:0] res;
    logic [63:0] exp;
    logic [31:0] a;
    logic [31:0] b;
    bit sgn;
    int edges, bb, exp_edges;
    for (int i = 0; i < 30; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = $urandom_range(1, 15);
        3:       b = 32'hFFFF_FFFF - $urandom_range(0, 3);
        4:       b = 32'h8000_0000;
        default: b = $urandom;
      endcase
      if (b == 32'd0 && $urandom_range(0, 1) == 1) b = 32'd1;
      exp       = ref_div(sgn, a, b);
      exp_edges = (b == 32'd0) ? 2 : 33;
      do_op(sgn, a, b, res, edges, bb);
      checks++; if (res !== exp) begin failures++; $display("FAIL rand_result idx=%0d got=%h exp=%h", i, res, exp); end
      checks++; if (edges !== exp_edges) begin failures++; $display("FAIL rand_latency idx=%0d got=%0d exp=%0d", i, edges, exp_edges); end
      checks++; if (bb !== 0) begin failures++; $display("FAIL rand_busy_wait idx=%0d low_cycles=%0d exp=0", i, bb); end
      release_op();
      checks++; if (bus.ready_o !== 1'b0) begin failures++; $display("FAIL rand_release_ready idx=%0d got=%b exp=0", i, bus.ready_o); end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_signed();
    test_div_zero();
    test_annul();
    test_hold_end();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
